// File: rtl/load_format_unit.sv
// Load-data formatter: lane extract + sign/zero extend + fault flagging, behind a 2-entry output buffer.
// Define LOAD_MERGE_EN to build the LWL/LWR unaligned-merge datapath; otherwise merge requests fault.
module load_format_unit #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_sign,
    input  logic [1:0]        in_merge,
    input  logic [DATA_W-1:0] in_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fault,
    output logic [CNT_W-1:0]  fault_cnt
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] lane;
    logic              lane_msb;
    logic [OFF_W-1:0]  align_mask;
    logic              size_bad;
    logic              misaligned;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_fault;

    always_comb begin
        shifted    = in_data >> {in_off, 3'b000};
        lane_mask  = '1;
        lane_msb   = shifted[DATA_W-1];
        align_mask = '0;
        case (in_size)
            2'd0: begin
                lane_mask  = DATA_W'(8'hFF);
                lane_msb   = shifted[7];
                align_mask = '0;
            end
            2'd1: begin
                lane_mask  = DATA_W'(16'hFFFF);
                lane_msb   = shifted[15];
                align_mask = OFF_W'(1);
            end
            2'd2: begin
                lane_mask  = DATA_W'(32'hFFFF_FFFF);
                lane_msb   = shifted[31];
                align_mask = OFF_W'(3);
            end
            default: begin
                lane_mask  = '1;
                lane_msb   = shifted[DATA_W-1];
                align_mask = OFF_W'(7);
            end
        endcase
        lane       = (shifted & lane_mask) | ({DATA_W{in_sign & lane_msb}} & ~lane_mask);
        size_bad   = int'(in_size) > OFF_W;
        misaligned = (in_off & align_mask) != '0;
    end

`ifdef LOAD_MERGE_EN
    logic [DATA_W-1:0] merge_data;

    // ~in_off == B-1-k, the number of rt bytes LWL keeps at the bottom.
    always_comb begin
        if (in_merge == 2'd1) begin
            merge_data = (in_data << {~in_off, 3'b000})
                       | (in_rt & ~({DATA_W{1'b1}} << {~in_off, 3'b000}));
        end else begin
            merge_data = (in_data >> {in_off, 3'b000})
                       | (in_rt & ~({DATA_W{1'b1}} >> {in_off, 3'b000}));
        end
    end
`else
    logic unused_rt;
    assign unused_rt = ^in_rt;
`endif

    always_comb begin
        fmt_data  = '0;
        fmt_fault = 1'b0;
        if (in_merge == 2'd3) begin
            fmt_fault = 1'b1;
        end else if (in_merge != 2'd0) begin
`ifdef LOAD_MERGE_EN
            fmt_data  = merge_data;
`else
            fmt_fault = 1'b1;
`endif
        end else if (size_bad || misaligned) begin
            fmt_fault = 1'b1;
        end else begin
            fmt_data  = lane;
        end
    end

    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              head_fault_q, head_fault_d;
    logic [DATA_W-1:0] tail_data_q, tail_data_d;
    logic              tail_fault_q, tail_fault_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  fault_cnt_q, fault_cnt_d;
    logic              push;
    logic              pop;

    assign in_ready  = (count_q != 2'd2) & ~rst;
    assign out_valid = count_q != 2'd0;
    assign out_data  = head_data_q;
    assign out_fault = head_fault_q;
    assign fault_cnt = fault_cnt_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_data_d  = head_data_q;
        head_fault_d = head_fault_q;
        tail_data_d  = tail_data_q;
        tail_fault_d = tail_fault_q;
        count_d      = count_q;
        fault_cnt_d  = fault_cnt_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_data_d  = fmt_data;
                    head_fault_d = fmt_fault;
                end else begin
                    tail_data_d  = fmt_data;
                    tail_fault_d = fmt_fault;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_data_d  = tail_data_q;
                head_fault_d = tail_fault_q;
                count_d      = count_q - 2'd1;
            end
            // Simultaneous push/pop only happens at count 1: new entry becomes head.
            2'b11: begin
                head_data_d  = fmt_data;
                head_fault_d = fmt_fault;
            end
            default: ;
        endcase
        if (push && fmt_fault && (fault_cnt_q != {CNT_W{1'b1}})) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data_q  <= '0;
            head_fault_q <= 1'b0;
            tail_data_q  <= '0;
            tail_fault_q <= 1'b0;
            count_q      <= 2'd0;
            fault_cnt_q  <= '0;
        end else begin
            head_data_q  <= head_data_d;
            head_fault_q <= head_fault_d;
            tail_data_q  <= tail_data_d;
            tail_fault_q <= tail_fault_d;
            count_q      <= count_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

endmodule

// File: tb/tb_load_format_unit.sv
// Scoreboard bench for load_format_unit: directed load/fault/backpressure/reset cases plus random traffic.
module tb_load_format_unit;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [OW-1:0] in_off;
    logic [1:0]    in_size;
    logic          in_sign;
    logic [1:0]    in_merge;
    logic [DW-1:0] in_rt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_fault;
    logic [CW-1:0] fault_cnt;

    logic or_man = 1'b0;
    logic or_rnd = 1'b0;
    bit   rnd_mode = 1'b0;
    assign out_ready = rnd_mode ? or_rnd : or_man;

    int total = 0;
    int bad = 0;
    logic [DW:0] sb[$];
    int exp_faults = 0;
    bit bp_done = 1'b0;

    localparam logic [DW:0] FAULT_V = {1'b1, {DW{1'b0}}};

    load_format_unit #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_off(in_off),
        .in_size(in_size), .in_sign(in_sign), .in_merge(in_merge), .in_rt(in_rt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_fault(out_fault), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        or_rnd = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bytes picked out of the word one by one, per the load rules.
    function automatic logic [DW:0] model(input logic [DW-1:0] d, input int off, input int size,
                                          input bit sign, input int merge, input logic [DW-1:0] rt);
        logic [7:0]    by[NB];
        logic [DW-1:0] r;
        int            n;
        bit            ext;
        for (int i = 0; i < NB; i++) by[i] = d[8*i +: 8];
        r = '0;
        if (merge == 3) return FAULT_V;
        if (merge != 0) begin
`ifdef LOAD_MERGE_EN
            for (int i = 0; i < NB; i++) begin
                if (merge == 1) begin
                    if (i >= NB - 1 - off) r[8*i +: 8] = by[i - (NB - 1 - off)];
                    else                   r[8*i +: 8] = rt[8*i +: 8];
                end else begin
                    if (i < NB - off) r[8*i +: 8] = by[i + off];
                    else              r[8*i +: 8] = rt[8*i +: 8];
                end
            end
            return {1'b0, r};
`else
            return FAULT_V;
`endif
        end
        n = 1 << size;
        if (n > NB || (off % n) != 0) return FAULT_V;
        ext = sign && by[off + n - 1][7];
        for (int i = 0; i < NB; i++) begin
            if (i < n) r[8*i +: 8] = by[off + i];
            else       r[8*i +: 8] = ext ? 8'hFF : 8'h00;
        end
        return {1'b0, r};
    endfunction

    always @(negedge clk) begin : monitor
        logic [DW:0] e;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stray_output: got fault=%b data=%h expected no output", out_fault, out_data);
            end else begin
                e = sb.pop_front();
                chk("result", 64'({out_fault, out_data}), 64'(e));
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input int off, input int size, input bit sign,
                        input int merge, input logic [DW-1:0] rt, input bit use_exp,
                        input logic [DW:0] expv);
        bit          done;
        logic [DW:0] e;
        done = 1'b0;
        e = use_exp ? expv : model(d, off, size, sign, merge, rt);
        in_valid = 1'b1;
        in_data  = d;
        in_off   = OW'(off);
        in_size  = 2'(size);
        in_sign  = sign;
        in_merge = 2'(merge);
        in_rt    = rt;
        for (int w = 0; w < 100 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                if (e[DW]) exp_faults++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles expected accept");
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW:0] head0;
        int          w;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_off   = '0;
        in_size  = 2'd2;
        in_sign  = 1'b0;
        in_merge = 2'd0;
        in_rt    = '0;

        // Request held during reset must not be taken.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fault_cnt", 64'(fault_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        or_man = 1'b1;

        send(32'h8765F0A1, 1, 0, 1, 0, 0, 1, {1'b0, 32'hFFFFFFF0});
        send(32'h8765F0A1, 1, 0, 0, 0, 0, 1, {1'b0, 32'h000000F0});
        send(32'h8765F0A1, 2, 1, 1, 0, 0, 1, {1'b0, 32'hFFFF8765});
        send(32'h8765F0A1, 0, 1, 1, 0, 0, 1, {1'b0, 32'hFFFFF0A1});
        send(32'h8765F0A1, 0, 1, 0, 0, 0, 1, {1'b0, 32'h0000F0A1});
        send(32'h8765F0A1, 0, 2, 1, 0, 0, 1, {1'b0, 32'h8765F0A1});
        drain();
        chk("fault_cnt_0", 64'(fault_cnt), 64'd0);

        send(32'h8765F0A1, 1, 1, 1, 0, 0, 1, FAULT_V);
        drain();
        chk("fault_cnt_1", 64'(fault_cnt), 64'd1);
        send(32'h8765F0A1, 0, 3, 0, 0, 0, 1, FAULT_V);
        drain();
        chk("fault_cnt_2", 64'(fault_cnt), 64'd2);

`ifdef LOAD_MERGE_EN
        send(32'h8765F0A1, 1, 0, 0, 1, 32'h11223344, 1, {1'b0, 32'hF0A13344});
        send(32'h8765F0A1, 1, 0, 0, 2, 32'h11223344, 1, {1'b0, 32'h118765F0});
`else
        send(32'h8765F0A1, 1, 0, 0, 1, 32'h11223344, 1, FAULT_V);
        send(32'h8765F0A1, 1, 0, 0, 2, 32'h11223344, 1, FAULT_V);
`endif
        send(32'h8765F0A1, 0, 2, 0, 3, 32'h11223344, 1, FAULT_V);
        drain();

        // Backpressure: three back-to-back requests against a stalled consumer.
        or_man = 1'b0;
        bp_done = 1'b0;
        fork
            begin
                send(32'hA5A5_1234, 0, 2, 0, 0, 0, 0, '0);
                send(32'h0000_80FF, 0, 1, 1, 0, 0, 0, '0);
                send(32'h1357_9BDF, 3, 0, 1, 0, 0, 0, '0);
                bp_done = 1'b1;
            end
        join_none
        repeat (3) @(negedge clk);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        head0 = {out_fault, out_data};
        chk("bp_head", 64'(head0), 64'(model(32'hA5A5_1234, 0, 2, 0, 0, 0)));
        @(negedge clk);
        chk("bp_hold_stable", 64'({out_fault, out_data}), 64'(head0));
        chk("bp_in_ready_held", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        or_man = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_pop_cycle", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("bp_in_ready_after_pop", 64'(in_ready), 64'd1);
        w = 0;
        while (!bp_done && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!bp_done) begin
            total++;
            bad++;
            $display("FAIL bp_sender: got sender stuck expected completion");
        end
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 300; i++) send($urandom, 0, 3, 0, 0, 0, 1, FAULT_V);
        drain();
        chk("fault_cnt_sat", 64'(fault_cnt), 64'd255);

        // Mid-stream reset with two entries buffered and three faults counted.
        rst = 1'b1;
        sb.delete();
        exp_faults = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h1, 1, 1, 0, 0, 0, 1, FAULT_V);
        drain();
        chk("fault_cnt_3", 64'(fault_cnt), 64'd3);
        or_man = 1'b0;
        send(32'h0102_0304, 0, 2, 0, 0, 0, 0, '0);
        send(32'h0506_0708, 0, 0, 0, 0, 0, 0, '0);
        @(negedge clk);
        chk("mid_full_in_ready", 64'(in_ready), 64'd0);
        chk("mid_full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        exp_faults = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_fault_cnt", 64'(fault_cnt), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        or_man = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_stale", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int m;
            m = ($urandom_range(0, 7) < 5) ? 0 : int'($urandom_range(1, 3));
            send($urandom, int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), m, $urandom, 0, '0);
        end
        rnd_mode = 1'b0;
        drain();
        chk("fault_cnt_random", 64'(fault_cnt), 64'((exp_faults > 255) ? 255 : exp_faults));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
